// File: rtl/mod_pkg.sv
// Shared types for the modular add/sub final select stage.
// Holds the default widths, FSM states, the entry bundle and the end-carry pick.
package mod_pkg;

  localparam int MOD_N     = 4;
  localparam int MOD_TAG_W = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [MOD_N-1:0]     r;
    logic                 sel;
    logic                 s;
    logic [MOD_TAG_W-1:0] tag;
  } entry_t;

  // Returns {sel, r}: v wins on a carry out of w or a b4 correction.
  function automatic logic [MOD_N:0] mod_pick(
    input logic [MOD_N:0] w,
    input logic [MOD_N:0] v,
    input logic           b4
  );
    logic sel;
    sel = w[MOD_N] | b4;
    return {sel, sel ? v[MOD_N-1:0] : w[MOD_N-1:0]};
  endfunction

endpackage

// File: rtl/mod_select_stage_if.sv
// Candidate-in / result-out valid-ready bus of the final select stage.
// slave is the stage side, master is the producer/consumer side.
interface mod_select_stage_if
  import mod_pkg::*;
#(
  parameter int N     = MOD_N,
  parameter int TAG_W = MOD_TAG_W
);

  logic             in_valid;
  logic             in_ready;
  logic [N:0]       in_w;
  logic [N:0]       in_v;
  logic             in_s;
  logic             in_b4;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_r;
  logic             out_sel;
  logic             out_s;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_w, in_v, in_s, in_b4, in_tag,
    input  out_ready,
    output in_ready,
    output out_valid, out_r, out_sel, out_s, out_tag
  );

  modport master (
    output in_valid, in_w, in_v, in_s, in_b4, in_tag,
    output out_ready,
    input  in_ready,
    input  out_valid, out_r, out_sel, out_s, out_tag
  );

endinterface

// File: rtl/mod_skid_buf.sv
// Generic 2-entry valid/ready skid buffer with registered in_ready/out_valid.
// Output always comes from the main register; the skid only refills it.
module mod_skid_buf
  import mod_pkg::*;
#(
  parameter type T = entry_t
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  state_t state;
  T       main_q;
  T       skid_q;
  logic   in_x;
  logic   out_x;

  assign in_x     = in_valid & in_ready;
  assign out_x    = out_valid & out_ready;
  assign out_data = main_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_x) begin
            main_q    <= in_data;
            state     <= ONE;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (in_x && out_x) begin
            main_q <= in_data;
          end else if (in_x) begin
            skid_q   <= in_data;
            state    <= FULL;
            in_ready <= 1'b0;
          end else if (out_x) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        FULL: begin
          if (out_x) begin
            main_q   <= skid_q;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mod_select_stage.sv
// Final modular add/sub stage: end-carry/correction pick into a skid buffer.
// Define MOD_SELECT_STATS_EN to add the stat_ops/stat_corr counters and stat_clr.
module mod_select_stage
  import mod_pkg::*;
#(
  parameter int N     = MOD_N,
  parameter int TAG_W = MOD_TAG_W
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef MOD_SELECT_STATS_EN
  input  logic                  stat_clr,
  output logic [15:0]           stat_ops,
  output logic [15:0]           stat_corr,
`endif
  mod_select_stage_if.slave     bus
);

  typedef struct packed {
    logic [N-1:0]     r;
    logic             sel;
    logic             s;
    logic [TAG_W-1:0] tag;
  } ent_t;

  logic         sel;
  logic [N-1:0] r;
  ent_t         in_ent;
  ent_t         out_ent;

  if (N == MOD_N) begin : g_pkg_pick
    always_comb begin
      {sel, r} = mod_pick(bus.in_w, bus.in_v, bus.in_b4);
    end
  end else begin : g_gen_pick
    always_comb begin
      sel = bus.in_w[N] | bus.in_b4;
      r   = sel ? bus.in_v[N-1:0] : bus.in_w[N-1:0];
    end
  end

  assign in_ent.r   = r;
  assign in_ent.sel = sel;
  assign in_ent.s   = bus.in_s;
  assign in_ent.tag = bus.in_tag;

  mod_skid_buf #(
    .T (ent_t)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (in_ent),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (out_ent)
  );

  assign bus.out_r   = out_ent.r;
  assign bus.out_sel = out_ent.sel;
  assign bus.out_s   = out_ent.s;
  assign bus.out_tag = out_ent.tag;

`ifdef MOD_SELECT_STATS_EN
  logic out_x;

  assign out_x = bus.out_valid & bus.out_ready;

  // Saturating counters; clear beats a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops  <= '0;
      stat_corr <= '0;
    end else if (stat_clr) begin
      stat_ops  <= '0;
      stat_corr <= '0;
    end else if (out_x) begin
      if (stat_ops != 16'hFFFF) begin
        stat_ops <= stat_ops + 16'd1;
      end
      if (out_ent.sel && stat_corr != 16'hFFFF) begin
        stat_corr <= stat_corr + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mod_select_stage.sv
// Bench for mod_select_stage: directed picks, backpressure, async reset, streams.
// Stats checks are active when MOD_SELECT_STATS_EN is defined.
module tb_mod_select_stage;
  import mod_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mod_select_stage_if #(.N(4), .TAG_W(2)) bus ();

`ifdef MOD_SELECT_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_ops;
  logic [15:0] stat_corr;
`endif

  mod_select_stage #(
    .N     (4),
    .TAG_W (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef MOD_SELECT_STATS_EN
    .stat_clr  (stat_clr),
    .stat_ops  (stat_ops),
    .stat_corr (stat_corr),
`endif
    .bus       (bus.slave)
  );

  typedef struct {
    logic [3:0] r;
    logic       sel;
    logic       s;
    logic [1:0] tag;
  } exp_t;

  int   errs   = 0;
  int   checks = 0;
  exp_t q[$];
  int   n_ops;
  int   n_corr;

  // Reference: v is chosen when w overflowed N bits or b4 asks for it.
  function automatic exp_t model_of(int w, int v, int b4, int s, int tag);
    exp_t e;
    bit   pick_v;
    pick_v = (w >= 16) || (b4 != 0);
    e.sel  = pick_v;
    e.r    = 4'(pick_v ? (v % 16) : (w % 16));
    e.s    = 1'(s);
    e.tag  = 2'(tag);
    return e;
  endfunction

  task automatic drive_idle();
    bus.in_valid  = 1'b0;
    bus.in_w      = '0;
    bus.in_v      = '0;
    bus.in_s      = 1'b0;
    bus.in_b4     = 1'b0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
`ifdef MOD_SELECT_STATS_EN
    stat_clr = 1'b0;
`endif
    #2;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
      errs++;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
      errs++;
    end
    checks++;
    if ({bus.out_r, bus.out_sel, bus.out_s, bus.out_tag} !== 8'h00) begin
      $display("FAIL reset_out_fields got=%h want=00",
               {bus.out_r, bus.out_sel, bus.out_s, bus.out_tag});
      errs++;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_select();
    int tw[3]   = '{6, 19, 15};
    int tv[3]   = '{7, 20, 0};
    int tb4[3]  = '{0, 0, 1};
    int ts[3]   = '{0, 1, 0};
    int ttag[3] = '{1, 2, 3};
    int er[3]   = '{6, 4, 0};
    int esel[3] = '{0, 1, 1};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_w      = 5'(tw[i]);
      bus.in_v      = 5'(tv[i]);
      bus.in_b4     = 1'(tb4[i]);
      bus.in_s      = 1'(ts[i]);
      bus.in_tag    = 2'(ttag[i]);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1) begin
        $display("FAIL select%0d_valid got=%b want=1", i, bus.out_valid);
        errs++;
      end
      checks++;
      if (bus.out_r !== 4'(er[i]) || bus.out_sel !== 1'(esel[i])) begin
        $display("FAIL select%0d_r_sel got=%h/%b want=%h/%b",
                 i, bus.out_r, bus.out_sel, er[i], esel[i]);
        errs++;
      end
      checks++;
      if (bus.out_s !== 1'(ts[i]) || bus.out_tag !== 2'(ttag[i])) begin
        $display("FAIL select%0d_s_tag got=%b/%0d want=%0d/%0d",
                 i, bus.out_s, bus.out_tag, ts[i], ttag[i]);
        errs++;
      end
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      $display("FAIL select_drain got=%b want=0", bus.out_valid);
      errs++;
    end
  endtask

  task automatic test_backpressure();
    int  got[$];
    bit  prev_acc;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_w      = 5'd3;
    bus.in_v      = 5'd9;
    bus.in_b4     = 1'b0;
    bus.in_tag    = 2'd0;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      $display("FAIL bp_ready_after1 got=%b want=1", bus.in_ready);
      errs++;
    end
    bus.in_tag = 2'd1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0) begin
      $display("FAIL bp_ready_after2 got=%b want=0", bus.in_ready);
      errs++;
    end
    bus.in_tag = 2'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1
          || bus.out_tag !== 2'd0) begin
        $display("FAIL bp_hold%0d rdy=%b vld=%b tag=%0d want 0/1/0",
                 i, bus.in_ready, bus.out_valid, bus.out_tag);
        errs++;
      end
    end
    bus.out_ready = 1'b1;
    prev_acc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i != 0) @(negedge clk);
      if (prev_acc) bus.in_valid = 1'b0;
      prev_acc = bus.in_valid & bus.in_ready;
      if (bus.out_valid) got.push_back(int'(bus.out_tag));
    end
    checks++;
    if (got.size() != 3) begin
      $display("FAIL bp_count got=%0d want=3", got.size());
      errs++;
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got[i] != i) begin
          $display("FAIL bp_order%0d got=%0d want=%0d", i, got[i], i);
          errs++;
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_w      = 5'b1_0001;
    bus.in_v      = 5'b1_0101;
    bus.in_b4     = 1'b0;
    bus.in_s      = 1'b1;
    bus.in_tag    = 2'd3;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.in_tag = 2'd2;
    @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
      $display("FAIL rstmid_full rdy=%b vld=%b want 0/1",
               bus.in_ready, bus.out_valid);
      errs++;
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      $display("FAIL rstmid_hs vld=%b rdy=%b want 0/1",
               bus.out_valid, bus.in_ready);
      errs++;
    end
    checks++;
    if ({bus.out_r, bus.out_sel, bus.out_s, bus.out_tag} !== 8'h00) begin
      $display("FAIL rstmid_fields got=%h want=00",
               {bus.out_r, bus.out_sel, bus.out_s, bus.out_tag});
      errs++;
    end
    @(negedge clk);
    rst = 1'b0;
    bus.in_s = 1'b0;
  endtask

  task automatic test_stream(input int n, input int n_sel, input int rdy_pct);
    bit   want[$];
    int   sent;
    int   cycles;
    bit   last_in_x;
    bit   in_x;
    bit   out_x;
    int   w;
    int   v;
    int   b4;
    exp_t e;
    for (int i = 0; i < n; i++) want.push_back(i < n_sel);
    for (int i = n - 1; i > 0; i--) begin
      int  j;
      bit  t;
      j = $urandom_range(i, 0);
      t = want[i];
      want[i] = want[j];
      want[j] = t;
    end
    q.delete();
    sent      = 0;
    cycles    = 0;
    n_ops     = 0;
    n_corr    = 0;
    last_in_x = 1'b0;
    bus.in_valid = 1'b0;
    while ((sent < n || q.size() != 0 || bus.in_valid) && cycles < 400) begin
      @(negedge clk);
      cycles++;
      checks++;
      if (bus.out_valid !== (q.size() != 0)
          || bus.in_ready !== (q.size() < 2)) begin
        $display("FAIL stream_hs cyc=%0d vld=%b rdy=%b depth=%0d",
                 cycles, bus.out_valid, bus.in_ready, q.size());
        errs++;
      end
      if (q.size() != 0) begin
        e = q[0];
        checks++;
        if (bus.out_r !== e.r || bus.out_sel !== e.sel
            || bus.out_s !== e.s || bus.out_tag !== e.tag) begin
          $display("FAIL stream_data cyc=%0d got=%h/%b/%b/%0d want=%h/%b/%b/%0d",
                   cycles, bus.out_r, bus.out_sel, bus.out_s, bus.out_tag,
                   e.r, e.sel, e.s, e.tag);
          errs++;
        end
      end
      if (!(bus.in_valid && !last_in_x)) begin
        if (sent < n) begin
          if (want[sent]) begin
            b4 = $urandom_range(1, 0);
            w  = (b4 != 0) ? $urandom_range(31, 0) : $urandom_range(31, 16);
          end else begin
            b4 = 0;
            w  = $urandom_range(15, 0);
          end
          v = $urandom_range(31, 0);
          bus.in_w     = 5'(w);
          bus.in_v     = 5'(v);
          bus.in_b4    = 1'(b4);
          bus.in_s     = 1'($urandom_range(1, 0));
          bus.in_tag   = 2'($urandom_range(3, 0));
          bus.in_valid = 1'b1;
          sent++;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      bus.out_ready = ($urandom_range(99, 0) < rdy_pct);
      out_x = (q.size() != 0) && bus.out_ready;
      in_x  = bus.in_valid && (q.size() < 2);
      if (out_x) begin
        n_ops++;
        if (q[0].sel) n_corr++;
        void'(q.pop_front());
      end
      if (in_x) begin
        q.push_back(model_of(int'(bus.in_w), int'(bus.in_v),
                             int'(bus.in_b4), int'(bus.in_s),
                             int'(bus.in_tag)));
      end
      last_in_x = in_x;
    end
    checks++;
    if (q.size() != 0 || n_ops != n) begin
      $display("FAIL stream_done ops=%0d want=%0d left=%0d", n_ops, n, q.size());
      errs++;
    end
    if (rdy_pct >= 100) begin
      checks++;
      if (cycles != n + 1) begin
        $display("FAIL stream_rate cycles=%0d want=%0d", cycles, n + 1);
        errs++;
      end
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

`ifdef MOD_SELECT_STATS_EN
  task automatic test_stats(input int want_ops, input int want_corr);
    checks++;
    if (stat_ops !== 16'(want_ops) || stat_corr !== 16'(want_corr)) begin
      $display("FAIL stats_count got=%0d/%0d want=%0d/%0d",
               stat_ops, stat_corr, want_ops, want_corr);
      errs++;
    end
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    checks++;
    if (stat_ops !== 16'd0 || stat_corr !== 16'd0) begin
      $display("FAIL stats_clr got=%0d/%0d want=0/0", stat_ops, stat_corr);
      errs++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_select();
    test_backpressure();
    test_reset_mid();
    test_stream(20, 7, 100);
    checks++;
    if (n_corr != 7) begin
      $display("FAIL stream_corr got=%0d want=7", n_corr);
      errs++;
    end
`ifdef MOD_SELECT_STATS_EN
    test_stats(20, 7);
`endif
    test_stream(60, 25, 55);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mod_select_stage.md
Name: mod_select_stage

Overview:
- Final stage of the modular adder/subtractor pipeline; the consumer end of the second-stage candidate bus.
- Accepts the two candidate sums (w, v), the operation flag s and the b4 correction flag from the second stage.
- Registers them, resolves the final modular result by end-carry/correction selection, and presents it on a valid/ready output through a 2-entry skid buffer.
- Decouples the combinational adder stages from a stalling downstream consumer.

Parameters:
- N, 4, operand width in bits; candidates are N+1 bits (bit N = carry).
- TAG_W, 2, width of the sideband tag carried alongside each operation.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  candidate set valid.
- in_ready  output  1  stage can accept a candidate set this cycle.
- in_w  input  N+1  candidate w = A + B + s (bit N = carry out).
- in_v  input  N+1  candidate v = corrected sum (bit N = carry out).
- in_s  input  1  operation: 0 = add, 1 = subtract.
- in_b4  input  1  correction flag from the second stage.
- in_tag  input  TAG_W  sideband tag, passed through unchanged.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts.
- out_r  output  N  modular result.
- out_sel  output  1  1 = v chosen, 0 = w chosen.
- out_s  output  1  operation flag of this result.
- out_tag  output  TAG_W  tag of this result.

Behaviour:
- Clock and reset: one clock. rst is asynchronous and active-high.
- Reset values: out_valid=0, in_ready=1, out_r=0, out_sel=0, out_s=0, out_tag=0, FSM=EMPTY.
- Selection: sel = in_w[N] | in_b4. out_r = sel ? in_v[N-1:0] : in_w[N-1:0]. Carry bits are discarded after selection; no other arithmetic is performed.
- Selection timing: sel is computed combinationally at the input and stored with the entry. The stored entry is {r, sel, s, tag}.
- Handshakes:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - in_ready = (state != FULL), registered.
  - out_valid = (state != EMPTY).
  - out_* remain stable while out_valid & !out_ready.
- Latency: 1 cycle from input transfer to out_valid when the stage is empty. Throughput is 1 per cycle while out_ready stays high.
- FSM states: EMPTY (0 entries), ONE (main register holds an entry), FULL (main + skid register).
  - EMPTY: input transfer -> ONE.
  - ONE: input and output transfer together -> ONE (main reloads). Input only -> FULL (new entry goes to skid). Output only -> EMPTY.
  - FULL: in_ready=0. Output transfer -> ONE (skid moves to main).
- Boundary conditions:
  - in_valid asserted while in_ready=0: ignored. The input side must hold its data.
  - Order is preserved: the skid entry always follows the main entry.
  - rst mid-operation: all entries dropped immediately, outputs take their reset values.
- Subtract path: in_s is only recorded. The second stage has already folded s into the candidates.

Optional Feature:
- Macro: MOD_SELECT_STATS_EN.
- With macro: adds outputs stat_ops[15:0] and stat_corr[15:0], both reset to 0.
  - stat_ops increments on every output transfer.
  - stat_corr increments on every output transfer with out_sel=1.
  - Both saturate at 16'hFFFF.
  - Adds input stat_clr, which synchronously zeroes both counters. stat_clr has priority over an increment in the same cycle.
- Without macro: these ports and counters do not exist. Core behaviour is identical.

Decomposition:
- Package mod_pkg:
  - state enum {EMPTY, ONE, FULL}.
  - Default N and TAG_W constants.
  - Entry struct {r, sel, s, tag}.
  - Function mod_pick(w, v, b4) returning {sel, r}.
- Sub-module mod_skid_buf: generic 2-entry valid/ready skid buffer on the entry struct. mod_select_stage = mod_pick + mod_skid_buf (+ optional counters).

Test Plan:
- Reset: assert rst mid-stream with 2 entries held -> out_valid=0, in_ready=1 and all out_* = 0 asynchronously, before the next clock edge.
- No correction: w=5'b0_0110, v=5'b0_0111, b4=0, s=0, tag=1, out_ready=1 -> next cycle out_r=4'h6, out_sel=0, out_tag=1.
- Carry select: w=5'b1_0011, v=5'b1_0100, b4=0, s=1 -> out_r=4'h4, out_sel=1, out_s=1.
- b4 select: w=5'b0_1111, v=5'b0_0000, b4=1 -> out_r=4'h0, out_sel=1.
- Backpressure: out_ready=0, send 3 sets (tags 0,1,2) -> in_ready drops after 2 accepted; tag 2 is held. Then out_ready=1 -> tags emerge 0,1,2 in order, none lost or duplicated.
- Streaming plus stats (MOD_SELECT_STATS_EN): 20 back-to-back sets with 7 selections of v -> one result per cycle after 1-cycle latency; stat_ops=20, stat_corr=7. stat_clr pulse -> both 0.
